// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM states and
// the set-2 scan codes the decoder treats specially.
package ps2_defs;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DATA   = 2'd1,
      PARITY = 2'd2,
      STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_BREAK = 8'hF0;
   localparam logic [7:0] PS2_EXT   = 8'hE0;
   localparam logic [7:0] PS2_ENTER = 8'h5A;
   localparam logic [7:0] PS2_BKSP  = 8'h66;
   localparam logic [7:0] PS2_SPACE = 8'h29;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Bundle between the PS/2 pins / text controller and the receiver.
// The slave modport is the receiver's view.
interface ps2_keyboard_rx_if;

   logic       iPS2_CLK;
   logic       iPS2_DAT;
   logic [7:0] oScanCode;
   logic [7:0] oKeyboardInput;
   logic       oAdvanceCursor;
   logic       oFrameErr;

   modport master (
      output iPS2_CLK,
      output iPS2_DAT,
      input  oScanCode,
      input  oKeyboardInput,
      input  oAdvanceCursor,
      input  oFrameErr
   );

   modport slave (
      input  iPS2_CLK,
      input  iPS2_DAT,
      output oScanCode,
      output oKeyboardInput,
      output oAdvanceCursor,
      output oFrameErr
   );

endinterface

// File: rtl/ps2_scan_to_ascii.sv
// Set-2 make code to ASCII lookup; hit is low for unmapped codes.
module ps2_scan_to_ascii
   import ps2_defs::*;
(
   input  logic [7:0] scan,
   output logic [7:0] ascii,
   output logic       hit
);

   always_comb begin
      ascii = 8'h00;
      hit   = 1'b1;
      case (scan)
         8'h1C: ascii = 8'h41;
         8'h32: ascii = 8'h42;
         8'h21: ascii = 8'h43;
         8'h23: ascii = 8'h44;
         8'h24: ascii = 8'h45;
         8'h2B: ascii = 8'h46;
         8'h34: ascii = 8'h47;
         8'h33: ascii = 8'h48;
         8'h43: ascii = 8'h49;
         8'h3B: ascii = 8'h4A;
         8'h42: ascii = 8'h4B;
         8'h4B: ascii = 8'h4C;
         8'h3A: ascii = 8'h4D;
         8'h31: ascii = 8'h4E;
         8'h44: ascii = 8'h4F;
         8'h4D: ascii = 8'h50;
         8'h15: ascii = 8'h51;
         8'h2D: ascii = 8'h52;
         8'h1B: ascii = 8'h53;
         8'h2C: ascii = 8'h54;
         8'h3C: ascii = 8'h55;
         8'h2A: ascii = 8'h56;
         8'h1D: ascii = 8'h57;
         8'h22: ascii = 8'h58;
         8'h35: ascii = 8'h59;
         8'h1A: ascii = 8'h5A;
         8'h45: ascii = 8'h30;
         8'h16: ascii = 8'h31;
         8'h1E: ascii = 8'h32;
         8'h26: ascii = 8'h33;
         8'h25: ascii = 8'h34;
         8'h2E: ascii = 8'h35;
         8'h36: ascii = 8'h36;
         8'h3D: ascii = 8'h37;
         8'h3E: ascii = 8'h38;
         8'h46: ascii = 8'h39;
         PS2_SPACE: ascii = 8'h20;
         PS2_ENTER: ascii = 8'h0D;
         PS2_BKSP:  ascii = 8'h08;
         default:   hit   = 1'b0;
      endcase
   end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver feeding the VGA text controller (VGA_CLK domain).
// Define PS2_PARITY_CHECK_EN to drop frames with bad odd parity.
module ps2_keyboard_rx
   import ps2_defs::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 25000
) (
   input  logic        iCLK,
   input  logic        iRST,
   ps2_keyboard_rx_if.slave kb
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]            clk_sync;
   logic [1:0]            dat_sync;
   logic [FILTER_LEN-1:0] clk_hist;
   logic [FILTER_LEN-1:0] dat_hist;
   logic                  clk_filt;
   logic                  dat_filt;
   logic                  clk_prev;
   logic                  fall;

   // A level is only accepted once the whole history window agrees.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         clk_sync <= '1;
         dat_sync <= '1;
         clk_hist <= '1;
         dat_hist <= '1;
         clk_filt <= 1'b1;
         dat_filt <= 1'b1;
         clk_prev <= 1'b1;
      end else begin
         clk_sync <= {clk_sync[0], kb.iPS2_CLK};
         dat_sync <= {dat_sync[0], kb.iPS2_DAT};
         clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_sync[1]};
         dat_hist <= {dat_hist[FILTER_LEN-2:0], dat_sync[1]};
         if (&clk_hist)
            clk_filt <= 1'b1;
         else if (~|clk_hist)
            clk_filt <= 1'b0;
         if (&dat_hist)
            dat_filt <= 1'b1;
         else if (~|dat_hist)
            dat_filt <= 1'b0;
         clk_prev <= clk_filt;
      end
   end

   assign fall = clk_prev & ~clk_filt;

   ps2_state_t state;
   logic [2:0]    bit_cnt;
   logic [7:0]    shreg;
   logic          par_bit;
   logic [TW-1:0] idle_cnt;
   logic          byte_valid;
   logic [7:0]    rx_byte;
   logic          frame_err;
   logic          frame_ok;

`ifdef PS2_PARITY_CHECK_EN
   assign frame_ok = dat_filt & (^{shreg, par_bit});
`else
   assign frame_ok = dat_filt;
`endif

   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         shreg      <= '0;
         par_bit    <= 1'b0;
         idle_cnt   <= '0;
         byte_valid <= 1'b0;
         rx_byte    <= '0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fall || state == IDLE)
            idle_cnt <= '0;
         else
            idle_cnt <= idle_cnt + 1'b1;

         // A stalled device must not wedge the receiver mid-frame.
         if (state != IDLE && !fall &&
             idle_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            shreg     <= '0;
            frame_err <= 1'b1;
         end else if (fall) begin
            case (state)
               IDLE: begin
                  if (!dat_filt) begin
                     state   <= DATA;
                     bit_cnt <= '0;
                  end
               end
               DATA: begin
                  shreg   <= {dat_filt, shreg[7:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7)
                     state <= PARITY;
               end
               PARITY: begin
                  par_bit <= dat_filt;
                  state   <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (frame_ok) begin
                     byte_valid <= 1'b1;
                     rx_byte    <= shreg;
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   logic [7:0] map_ascii;
   logic       map_hit;

   ps2_scan_to_ascii u_map (
      .scan  (rx_byte),
      .ascii (map_ascii),
      .hit   (map_hit)
   );

   logic [7:0] scan_q;
   logic [7:0] char_q;
   logic       adv_q;
   logic       brk_flag;
   logic       ext_flag;

   // Prefix bytes arm flags; the byte that follows a prefix is swallowed.
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         scan_q   <= '0;
         char_q   <= '0;
         adv_q    <= 1'b0;
         brk_flag <= 1'b0;
         ext_flag <= 1'b0;
      end else begin
         adv_q <= 1'b0;
         if (byte_valid) begin
            if (rx_byte == PS2_EXT) begin
               ext_flag <= 1'b1;
            end else if (rx_byte == PS2_BREAK) begin
               brk_flag <= 1'b1;
            end else if (brk_flag || ext_flag) begin
               brk_flag <= 1'b0;
               ext_flag <= 1'b0;
            end else begin
               scan_q <= rx_byte;
               if (map_hit) begin
                  char_q <= map_ascii;
                  adv_q  <= 1'b1;
               end
            end
         end
      end
   end

   assign kb.oScanCode      = scan_q;
   assign kb.oKeyboardInput = char_q;
   assign kb.oAdvanceCursor = adv_q;
   assign kb.oFrameErr      = frame_err;

endmodule
